// File: rtl/md_sched.sv
// rtl/md_sched.sv - EX-stage multiply/divide sequencer owning the HI/LO pair
//
// Purpose: launches the external pipelined multiplier or stream divider on
// latched operand magnitudes, stalls the pipeline for the unit latency,
// applies sign correction and commits results to HI/LO. MFHI/MFLO/MTHI/MTLO
// complete in a single cycle.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   Md_op               4-bit operation from EX
//   Rs_in, Rt_in        operands, held by the pipeline while Md_stall=1
//   Res_out             EX result (HI, LO or MUL low word)
//   Md_stall            combinational pipeline freeze
//   mul_a, mul_b        registered multiplier operands
//   mul_res             unsigned 64-bit product
//   div_start           one-cycle tvalid pulse to the divider
//   div_a, div_b        registered dividend / divisor
//   div_valid, div_res  divider result handshake {quotient, remainder}
module md_sched #(
    parameter int MUL_LAT = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [3:0]  Md_op,
    input  logic [31:0] Rs_in,
    input  logic [31:0] Rt_in,
    output logic [31:0] Res_out,
    output logic        Md_stall,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_res,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_valid,
    input  logic [63:0] div_res
);

    localparam logic [3:0] OP_DIV   = 4'b0001;
    localparam logic [3:0] OP_DIVU  = 4'b0010;
    localparam logic [3:0] OP_MFHI  = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MUL   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;

    localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_mul_lo;
    logic            r_mul_only;
    logic            r_neg;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_div_start;
    logic [31:0]     r_mul_a;
    logic [31:0]     r_mul_b;
    logic [31:0]     r_div_a;
    logic [31:0]     r_div_b;

    logic            w_is_mul;
    logic            w_is_div;
    logic            w_long;
    logic            w_signed;
    logic            w_div_zero;
    logic [31:0]     w_rs_mag;
    logic [31:0]     w_rt_mag;
    logic [63:0]     w_prod;
    logic [31:0]     w_quot;
    logic [31:0]     w_rem;

    assign w_is_mul   = (Md_op == OP_MUL) || (Md_op == OP_MULT) || (Md_op == OP_MULTU);
    assign w_is_div   = (Md_op == OP_DIV) || (Md_op == OP_DIVU);
    assign w_long     = w_is_mul || w_is_div;
    assign w_signed   = (Md_op == OP_MUL) || (Md_op == OP_MULT) || (Md_op == OP_DIV);
    assign w_div_zero = (Rt_in == 32'd0);

    // Magnitude of -2^31 is 0x80000000, which is still correct as unsigned.
    assign w_rs_mag = Rs_in[31] ? (32'd0 - Rs_in) : Rs_in;
    assign w_rt_mag = Rt_in[31] ? (32'd0 - Rt_in) : Rt_in;

    assign w_prod = r_neg  ? (64'd0 - mul_res) : mul_res;
    assign w_quot = r_qneg ? (32'd0 - div_res[63:32]) : div_res[63:32];
    assign w_rem  = r_rneg ? (32'd0 - div_res[31:0])  : div_res[31:0];

    assign Md_stall  = w_long && (r_state != S_DONE);
    assign div_start = r_div_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;

    always_comb begin
        Res_out = 32'd0;
        case (Md_op)
            OP_MFHI: Res_out = r_hi;
            OP_MFLO: Res_out = r_lo;
            OP_MUL:  if (r_state == S_DONE) Res_out = r_mul_lo;
            default: Res_out = 32'd0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_is_mul)
                    w_next_state = S_MUL_WAIT;
                else if (w_is_div)
                    w_next_state = w_div_zero ? S_DONE : S_DIV_WAIT;
            end
            S_MUL_WAIT: if (r_cnt == CW'(1)) w_next_state = S_DONE;
            S_DIV_WAIT: if (div_valid) w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt       <= '0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_mul_lo    <= 32'd0;
            r_mul_only  <= 1'b0;
            r_neg       <= 1'b0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_div_start <= 1'b0;
            r_mul_a     <= 32'd0;
            r_mul_b     <= 32'd0;
            r_div_a     <= 32'd0;
            r_div_b     <= 32'd0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_mul) begin
                        r_mul_a    <= w_signed ? w_rs_mag : Rs_in;
                        r_mul_b    <= w_signed ? w_rt_mag : Rt_in;
                        r_neg      <= w_signed & (Rs_in[31] ^ Rt_in[31]);
                        r_mul_only <= (Md_op == OP_MUL);
                        r_cnt      <= CW'(MUL_LAT);
                    end else if (w_is_div) begin
                        if (w_div_zero) begin
                            r_lo <= 32'hFFFF_FFFF;
                            r_hi <= Rs_in;
                        end else begin
                            r_div_a     <= w_signed ? w_rs_mag : Rs_in;
                            r_div_b     <= w_signed ? w_rt_mag : Rt_in;
                            r_qneg      <= w_signed & (Rs_in[31] ^ Rt_in[31]);
                            r_rneg      <= w_signed & Rs_in[31];
                            r_div_start <= 1'b1;
                        end
                    end else if (Md_op == OP_MTHI) begin
                        r_hi <= Rs_in;
                    end else if (Md_op == OP_MTLO) begin
                        r_lo <= Rs_in;
                    end
                end
                S_MUL_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        // MUL writes only its GPR result; HI/LO stay architectural.
                        if (r_mul_only)
                            r_mul_lo <= w_prod[31:0];
                        else begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                    end
                end
                S_DIV_WAIT: begin
                    if (div_valid) begin
                        r_lo <= w_quot;
                        r_hi <= w_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
